// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache with a single outstanding
// line fill. Responses are registered one-cycle pulses on inst_get_ready.
module icache #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        pc_send_enable,
  input  logic [31:0] pc_from_if,
  output logic        inst_get_ready,
  output logic [31:0] inst_to_if,
  input  logic        jump_flag,
  output logic        mem_req_enable,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 32 - INDEX_BITS - 2;

  typedef enum logic {IDLE, MISS} state_t;

  state_t                        r_state, w_state_nxt;
  logic                          r_cancel;
  logic                          r_ready;
  logic [31:0]                   r_inst;
  logic                          r_mem_req;
  logic [31:0]                   r_mem_addr;
  logic [LINES-1:0]              r_valid;
  logic [LINES-1:0][TAG_W-1:0]   r_tag;
  logic [LINES-1:0][31:0]        r_data;

  logic [INDEX_BITS-1:0] w_idx, w_fill_idx;
  logic [TAG_W-1:0]      w_tag, w_fill_tag;
  logic                  w_hit_line;
  logic                  w_miss, w_fill, w_rsp;
  logic [31:0]           w_rsp_data;
  logic                  w_unused;

  assign w_idx      = pc_from_if[INDEX_BITS+1:2];
  assign w_tag      = pc_from_if[31:INDEX_BITS+2];
  // The latched fill address doubles as the pending miss pc.
  assign w_fill_idx = r_mem_addr[INDEX_BITS+1:2];
  assign w_fill_tag = r_mem_addr[31:INDEX_BITS+2];
  assign w_hit_line = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_unused   = ^{pc_from_if[1:0], r_mem_addr[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_miss      = 1'b0;
    w_fill      = 1'b0;
    w_rsp       = 1'b0;
    w_rsp_data  = r_data[w_idx];
    case (r_state)
      IDLE: begin
        // r_ready blocks back-to-back accepts so responses never abut.
        if (rdy && !jump_flag && pc_send_enable && !r_ready) begin
          if (w_hit_line) begin
            w_rsp = 1'b1;
          end else begin
            w_miss      = 1'b1;
            w_state_nxt = MISS;
          end
        end
      end
      MISS: begin
        if (rdy && mem_done) begin
          w_fill      = 1'b1;
          w_state_nxt = IDLE;
          if (!r_cancel && !jump_flag) begin
            w_rsp      = 1'b1;
            w_rsp_data = mem_data;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cancel   <= 1'b0;
      r_ready    <= 1'b0;
      r_inst     <= '0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_valid    <= '0;
    end else if (rdy) begin
      r_ready <= w_rsp;
      if (w_rsp) r_inst <= w_rsp_data;
      if (w_miss) begin
        r_mem_req  <= 1'b1;
        r_mem_addr <= {pc_from_if[31:2], 2'b00};
      end
      if (w_fill) begin
        r_mem_req          <= 1'b0;
        r_valid[w_fill_idx] <= 1'b1;
      end
      if (w_fill)                            r_cancel <= 1'b0;
      else if (r_state == MISS && jump_flag) r_cancel <= 1'b1;
    end else begin
      r_ready <= 1'b0;
    end
  end

  // Tag and data need no reset; the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= mem_data;
    end
  end

  assign inst_get_ready = r_ready;
  assign inst_to_if     = r_inst;
  assign mem_req_enable = r_mem_req;
  assign mem_addr       = r_mem_addr;
endmodule
